// File: rtl/iob_ram_t2p_arb_pkg.sv
// Shared parameter defaults for the two-port RAM arbiter slice.
package iob_ram_t2p_arb_pkg;
   localparam int N_REQ_DEF  = 2;
   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/iob_ram_t2p_arb_rr_arbiter.sv
// Round-robin arbiter: searches upward from a pointer, one-hot grant,
// pointer moves past the winner only when the caller lets the grant stand.
module iob_rr_arbiter #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk_i,
   input  logic         arst_n_i,
   input  logic [N-1:0] req_i,
   input  logic         adv_i,
   output logic [N-1:0] gnt_o
);
   logic [IW-1:0] r_ptr;
   logic [IW-1:0] w_idx;
   logic          w_hit;

   always_comb begin
      int j;
      j     = 0;
      gnt_o = '0;
      w_idx = r_ptr;
      w_hit = 1'b0;
      for (int i = 0; i < N; i++) begin
         j = int'(r_ptr) + i;
         if (j >= N) j = j - N;
         if (!w_hit && req_i[j]) begin
            w_hit    = 1'b1;
            gnt_o[j] = 1'b1;
            w_idx    = IW'(j);
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i)
         r_ptr <= '0;
      else if (w_hit && adv_i)
         r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
   end
endmodule

// File: rtl/iob_ram_t2p_arb.sv
// Arbitrates N requesters onto a 1R1W RAM: independent read/write
// round-robin, read withheld on same-address collision with the write.
module iob_ram_t2p_arb
   import iob_ram_t2p_arb_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                     clk_i,
   input  logic                     arst_n_i,
   input  logic [N_REQ-1:0]         req_valid_i,
   input  logic [N_REQ-1:0]         req_we_i,
   input  logic [N_REQ*ADDR_W-1:0]  req_addr_i,
   input  logic [N_REQ*DATA_W-1:0]  req_wdata_i,
   output logic [N_REQ-1:0]         req_ready_o,
   output logic [N_REQ-1:0]         rsp_valid_o,
   output logic [DATA_W-1:0]        rsp_rdata_o,
   output logic                     w_en_o,
   output logic [ADDR_W-1:0]        w_addr_o,
   output logic [DATA_W-1:0]        w_data_o,
   output logic                     r_en_o,
   output logic [ADDR_W-1:0]        r_addr_o,
   input  logic [DATA_W-1:0]        r_data_i
);
   logic [N_REQ-1:0]  w_wr_cand, w_rd_cand;
   logic [N_REQ-1:0]  w_wr_gnt, w_rd_gnt_raw, w_rd_gnt;
   logic [ADDR_W-1:0] w_waddr, w_raddr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_conflict;
   logic [N_REQ-1:0]  r_rsp_vld;

   // Gating with reset keeps every grant-derived output quiet while held in reset.
   assign w_wr_cand = req_valid_i &  req_we_i & {N_REQ{arst_n_i}};
   assign w_rd_cand = req_valid_i & ~req_we_i & {N_REQ{arst_n_i}};

   iob_rr_arbiter #(.N(N_REQ)) u_wr_arb (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .req_i    (w_wr_cand),
      .adv_i    (1'b1),
      .gnt_o    (w_wr_gnt)
   );

   iob_rr_arbiter #(.N(N_REQ)) u_rd_arb (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .req_i    (w_rd_cand),
      .adv_i    (~w_conflict),
      .gnt_o    (w_rd_gnt_raw)
   );

   always_comb begin
      w_waddr = '0;
      w_wdata = '0;
      w_raddr = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_wr_gnt[k]) begin
            w_waddr = req_addr_i[k*ADDR_W +: ADDR_W];
            w_wdata = req_wdata_i[k*DATA_W +: DATA_W];
         end
         if (w_rd_gnt_raw[k])
            w_raddr = req_addr_i[k*ADDR_W +: ADDR_W];
      end
   end

   // A read colliding with this cycle's write retries next cycle and sees new data.
   assign w_conflict = (|w_wr_gnt) & (|w_rd_gnt_raw) & (w_waddr == w_raddr);
   assign w_rd_gnt   = w_rd_gnt_raw & {N_REQ{~w_conflict}};

   assign req_ready_o = w_wr_gnt | w_rd_gnt;
   assign w_en_o      = |w_wr_gnt;
   assign w_addr_o    = w_waddr;
   assign w_data_o    = w_wdata;
   assign r_en_o      = |w_rd_gnt;
   assign r_addr_o    = r_en_o ? w_raddr : '0;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) r_rsp_vld <= '0;
      else           r_rsp_vld <= w_rd_gnt;
   end

   assign rsp_valid_o = r_rsp_vld;
   assign rsp_rdata_o = (|r_rsp_vld) ? r_data_i : '0;
endmodule

// File: tb/tb_iob_ram_t2p_arb.sv
// Directed bench with a response scoreboard for iob_ram_t2p_arb.
module tb_iob_ram_t2p_arb;
   localparam int N = 2, AW = 10, DW = 32;

   logic            clk = 1'b0, arst_n = 1'b0;
   logic [N-1:0]    req_valid = '0, req_we = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N-1:0]    req_ready, rsp_valid;
   logic [DW-1:0]   rsp_rdata, w_data, r_data;
   logic [AW-1:0]   w_addr, r_addr;
   logic            w_en, r_en;

   typedef struct { logic [N-1:0] vld; logic [DW-1:0] data; int cyc; } exp_t;
   exp_t q[$];
   int errs = 0, checks = 0, cyc = 0;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   iob_ram_t2p_arb #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i(clk), .arst_n_i(arst_n),
      .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
      .w_en_o(w_en), .w_addr_o(w_addr), .w_data_o(w_data),
      .r_en_o(r_en), .r_addr_o(r_addr), .r_data_i(r_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioral RAM, 1-cycle read latency
   initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
   always @(posedge clk) begin
      if (w_en) mem[w_addr] <= w_data;
      if (r_en) r_data <= mem[r_addr];
   end

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: every response must match the head of the scoreboard in value and cycle.
   always @(negedge clk) begin
      if (arst_n) begin
         if (|rsp_valid) begin
            if (q.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'h0);
            else begin
               exp_t e;
               e = q.pop_front();
               chk("rsp_valid", 64'(rsp_valid), 64'(e.vld));
               chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
               chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
            end
         end else begin
            chk("rdata_idle_zero", 64'(rsp_rdata), 64'h0);
         end
      end
   end

   task automatic step(); @(posedge clk); #1; endtask
   task automatic settle(); #3; endtask

   task automatic set_req(int k, logic v, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
      req_valid[k] = v;
      req_we[k]    = we;
      req_addr[k*AW +: AW]  = a;
      req_wdata[k*DW +: DW] = d;
   endtask

   task automatic expect_rsp(logic [N-1:0] v, logic [DW-1:0] d);
      exp_t e;
      e.vld = v; e.data = d; e.cyc = cyc + 1;
      q.push_back(e);
   endtask

   initial begin
      int g0, g1;
      // Reset state: requests present but nothing granted
      step();
      set_req(0, 1, 1, 10'd3, 32'h1);
      set_req(1, 1, 0, 10'd4, 32'h0);
      settle();
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_w_en", 64'(w_en), 64'h0);
      chk("rst_r_en", 64'(r_en), 64'h0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
      req_valid = '0;
      step();
      arst_n = 1'b1;

      // Single write k0 addr5 data A5, accepted on first edge after release
      set_req(0, 1, 1, 10'd5, 32'hA5);
      settle();
      chk("wr_ready", 64'(req_ready), 64'h1);
      chk("wr_w_en", 64'(w_en), 64'h1);
      chk("wr_w_addr", 64'(w_addr), 64'd5);
      chk("wr_w_data", 64'(w_data), 64'hA5);
      chk("wr_r_en", 64'(r_en), 64'h0);
      step();
      // k1 reads addr 5
      set_req(0, 0, 0, 10'd0, 32'h0);
      set_req(1, 1, 0, 10'd5, 32'h0);
      settle();
      chk("rd_ready", 64'(req_ready), 64'h2);
      chk("rd_r_en", 64'(r_en), 64'h1);
      chk("rd_r_addr", 64'(r_addr), 64'd5);
      expect_rsp(2'b10, 32'hA5);
      step();
      req_valid = '0;

      // Same-address collision: write k0 addr7 0x11, read k1 addr7
      step();
      set_req(0, 1, 1, 10'd7, 32'h11);
      set_req(1, 1, 0, 10'd7, 32'h0);
      settle();
      chk("col_ready", 64'(req_ready), 64'h1);
      chk("col_r_en", 64'(r_en), 64'h0);
      chk("col_w_en", 64'(w_en), 64'h1);
      step();
      set_req(0, 0, 0, 10'd0, 32'h0);
      settle();
      chk("col_retry_ready", 64'(req_ready), 64'h2);
      chk("col_retry_r_en", 64'(r_en), 64'h1);
      expect_rsp(2'b10, 32'h11);
      step();
      req_valid = '0;

      // Write and read to different addresses in one cycle
      step();
      set_req(0, 1, 1, 10'd9, 32'h99);
      set_req(1, 1, 0, 10'd5, 32'h0);
      settle();
      chk("par_ready", 64'(req_ready), 64'h3);
      chk("par_w_addr", 64'(w_addr), 64'd9);
      chk("par_r_addr", 64'(r_addr), 64'd5);
      expect_rsp(2'b10, 32'hA5);
      step();
      req_valid = '0;

      // k0 read granted (read ptr -> 1), then reset lands in the response cycle
      step();
      set_req(0, 1, 0, 10'd5, 32'h0);
      settle();
      chk("pre_rst_ready", 64'(req_ready), 64'h1);
      step();
      req_valid = '0;
      arst_n = 1'b0;
      #1;
      chk("rst_inflight_rsp", 64'(rsp_valid), 64'h0);
      step();
      chk("rst_hold_rsp", 64'(rsp_valid), 64'h0);
      arst_n = 1'b1;
      step();
      chk("post_rst_rsp", 64'(rsp_valid), 64'h0);

      // Both write continuously 8 cycles: 0,1,0,1...
      g0 = 0; g1 = 0;
      set_req(0, 1, 1, 10'd20, 32'h200);
      set_req(1, 1, 1, 10'd21, 32'h211);
      for (int i = 0; i < 8; i++) begin
         settle();
         chk("alt_ready", 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
         chk("alt_w_addr", 64'(w_addr), (i % 2 == 0) ? 64'd20 : 64'd21);
         if (req_ready[0]) g0++;
         if (req_ready[1]) g1++;
         step();
      end
      chk("alt_cnt0", 64'(g0), 64'd4);
      chk("alt_cnt1", 64'(g1), 64'd4);

      // Both read: read pointer was reset, so k0 first, then k1 back-to-back
      set_req(0, 1, 0, 10'd7, 32'h0);
      set_req(1, 1, 0, 10'd21, 32'h0);
      settle();
      chk("rr_rd_first", 64'(req_ready), 64'h1);
      expect_rsp(2'b01, 32'h11);
      step();
      set_req(0, 0, 0, 10'd0, 32'h0);
      settle();
      chk("rr_rd_second", 64'(req_ready), 64'h2);
      expect_rsp(2'b10, 32'h211);
      step();
      req_valid = '0;

      // Valid dropping without grant leaves nothing behind
      step();
      step();
      chk("drain_q", 64'(q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/iob_ram_t2p_arb.md
IOB_RAM_T2P_ARB -- requirements
Module: iob_ram_t2p_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 2: number of requesters, range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 10: RAM address width.
REQ-003 SHALL have parameter DATA_W, default 32: RAM data width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port arst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  N_REQ  per-requester access request.
REQ-007 SHALL have port req_we_i  input  N_REQ  per-requester 1=write, 0=read.
REQ-008 SHALL have port req_addr_i  input  N_REQ*ADDR_W  packed addresses, requester k at bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_wdata_i  input  N_REQ*DATA_W  packed write data, same packing.
REQ-010 SHALL have port req_ready_o  output  N_REQ  grant; request accepted when valid&ready.
REQ-011 SHALL have port rsp_valid_o  output  N_REQ  read data valid for requester k.
REQ-012 SHALL have port rsp_rdata_o  output  DATA_W  shared read data bus.
REQ-013 SHALL have ports w_en_o 1, w_addr_o ADDR_W, w_data_o DATA_W (outputs): RAM write port.
REQ-014 SHALL have ports r_en_o 1, r_addr_o ADDR_W (outputs), r_data_i DATA_W (input): RAM read port, 1-cycle latency.

Function
REQ-015 SHALL run two independent round-robin arbiters: write (candidates valid&we) and read (candidates valid&~we).
REQ-016 SHALL grant at most one write and one read per cycle; one requester never receives both.
REQ-017 SHALL drive req_ready_o combinationally in the same cycle as the request; ready never asserts without valid.
REQ-018 SHALL, on write grant to k, drive w_en_o=1, w_addr_o/w_data_o from requester k in that cycle; otherwise w_en_o=0.
REQ-019 SHALL, on read grant to k, drive r_en_o=1, r_addr_o from requester k; otherwise r_en_o=0.
REQ-020 SHALL assert rsp_valid_o[k] exactly one cycle after read grant to k, for one cycle, with rsp_rdata_o=r_data_i.
REQ-021 SHALL hold rsp_rdata_o at 0 when no bit of rsp_valid_o is set.
REQ-022 SHALL search each arbiter from its pointer upward, modulo N_REQ; after a grant to k, pointer becomes (k+1) mod N_REQ; no grant leaves it unchanged.
REQ-023 SHALL, when granted read and granted write target the same address in one cycle, withhold the read grant (read retries next cycle, returns new data); the write proceeds and the read pointer is unchanged.
REQ-024 SHALL tolerate req_valid_i dropping without grant; no state change results.
REQ-025 SHALL guarantee each continuously requesting requester is granted within N_REQ cycles on its port type.

Reset
REQ-026 SHALL, while arst_n_i=0, force both pointers=0, rsp_valid_o=0, rsp_rdata_o=0; combinational outputs follow zero grants.
REQ-027 SHALL discard a read in flight when reset asserts; no rsp_valid_o after release.
REQ-028 SHALL accept requests on the first rising edge after reset release.

Structure
REQ-029 SHALL place no typedefs in a package; parameters only; index widths from $clog2(N_REQ).
REQ-030 SHALL implement each arbiter as one instance of sub-module iob_rr_arbiter (N inputs, pointer register, one-hot grant, advance enable).
REQ-031 SHALL contain one response register: one-hot rsp_valid state of N_REQ bits.

Verification
REQ-032 SHALL verify: reset then single write k=0 addr 5 data 0xA5 -> ready[0]=1 same cycle, w_en_o=1, w_addr_o=5.
REQ-033 SHALL verify: k=1 read addr 5 after that write -> r_en_o=1, next cycle rsp_valid_o=2'b10, rsp_rdata_o=0xA5.
REQ-034 SHALL verify: both requesters write continuously 8 cycles -> grants alternate 0,1,0,1..., 4 each.
REQ-035 SHALL verify: k=0 writes addr 7 data 0x11 while k=1 reads addr 7 -> read stalled 1 cycle, then rsp_rdata_o=0x11.
REQ-036 SHALL verify: k=0 write and k=1 read to different addresses same cycle -> both granted, rsp_valid_o[1] next cycle.
REQ-037 SHALL verify: arst_n_i low during cycle after read grant -> rsp_valid_o stays 0, pointers 0 after release.
